// File: rtl/conv_frame_encoder.sv
// Rate-1/2 convolutional frame encoder: FRAME_LEN info bits plus K-1 zero tail bits per frame.
// Optional rate-2/3 puncturing ([11;10]) is built when the macro PUNCTURE_EN is defined.
module conv_frame_encoder #(
    parameter int           K         = 3,
    parameter logic [K-1:0] G0        = 3'b111,
    parameter logic [K-1:0] G1        = 3'b101,
    parameter int           FRAME_LEN = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_i,
    input  logic        data_valid_i,
    output logic        data_ready_o,
    output logic [1:0]  enc_o,
    output logic [1:0]  enc_mask_o,
    output logic        enc_valid_o,
    input  logic        enc_ready_i,
    output logic        frame_start_o,
    output logic        frame_end_o,
    output logic [15:0] frame_ct_o
);

    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int TW = (K > 2) ? $clog2(K - 1) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(FRAME_LEN - 1);
    localparam logic [TW-1:0] TAIL_LAST = TW'(K - 2);

    typedef enum logic {
        S_DATA = 1'b0,
        S_TAIL = 1'b1
    } state_t;

    state_t        state_reg;
    logic [CW-1:0] bit_cnt_reg;
    logic [TW-1:0] tail_cnt_reg;
    logic [K-2:0]  sr_reg;
    logic [K-2:0]  sr_next;
    logic [1:0]    enc_reg;
    logic          enc_valid_reg;
    logic          frame_start_reg;
    logic          frame_end_reg;
    logic [15:0]   frame_ct_reg;

    logic          adv;
    logic          emit;
    logic          enc_bit;
    logic [K-1:0]  u_vec;
    logic [1:0]    sym_raw;
    logic [1:0]    sym_next;

    assign adv          = ~enc_valid_reg | enc_ready_i;
    assign data_ready_o = (state_reg == S_DATA) & adv;
    assign emit         = (state_reg == S_DATA) ? (data_valid_i & adv) : adv;
    // Tail cycles feed zeros so the trellis always returns to state 0.
    assign enc_bit      = (state_reg == S_DATA) ? data_i : 1'b0;

    // u = {b, sr[0], sr[1], ...}: MSB is the current bit, sr[0] the most recent past bit.
    assign u_vec[K-1] = enc_bit;
    generate
        for (genvar gi = 0; gi < K - 1; gi++) begin : g_taps
            assign u_vec[K-2-gi] = sr_reg[gi];
        end
        if (K > 2) begin : g_sr_wide
            assign sr_next = {sr_reg[K-3:0], enc_bit};
        end else begin : g_sr_narrow
            assign sr_next = enc_bit;
        end
    endgenerate

    assign sym_raw = {^(u_vec & G0), ^(u_vec & G1)};

`ifdef PUNCTURE_EN
    logic       phase_reg;
    logic       cur_phase;
    logic [1:0] mask_reg;
    logic [1:0] mask_next;

    // Symbol index parity restarts at every frame's first info bit; tail symbols continue it.
    assign cur_phase  = (state_reg == S_DATA && bit_cnt_reg == '0) ? 1'b0 : phase_reg;
    assign sym_next   = cur_phase ? {sym_raw[1], 1'b0} : sym_raw;
    assign mask_next  = cur_phase ? 2'b10 : 2'b11;
    assign enc_mask_o = mask_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_reg <= 1'b0;
            mask_reg  <= 2'b11;
        end else if (emit) begin
            phase_reg <= ~cur_phase;
            mask_reg  <= mask_next;
        end
    end
`else
    assign sym_next   = sym_raw;
    assign enc_mask_o = 2'b11;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_DATA;
            bit_cnt_reg     <= '0;
            tail_cnt_reg    <= '0;
            sr_reg          <= '0;
            enc_reg         <= 2'b00;
            enc_valid_reg   <= 1'b0;
            frame_start_reg <= 1'b0;
            frame_end_reg   <= 1'b0;
            frame_ct_reg    <= 16'd0;
        end else if (adv) begin
            if (emit) begin
                enc_reg       <= sym_next;
                enc_valid_reg <= 1'b1;
                sr_reg        <= sr_next;
                if (state_reg == S_DATA) begin
                    frame_start_reg <= (bit_cnt_reg == '0);
                    frame_end_reg   <= 1'b0;
                    if (bit_cnt_reg == BIT_LAST) begin
                        bit_cnt_reg <= '0;
                        state_reg   <= S_TAIL;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    end
                end else begin
                    frame_start_reg <= 1'b0;
                    if (tail_cnt_reg == TAIL_LAST) begin
                        frame_end_reg <= 1'b1;
                        frame_ct_reg  <= frame_ct_reg + 16'd1;
                        tail_cnt_reg  <= '0;
                        state_reg     <= S_DATA;
                        // Already zero after the flush; cleared anyway as a hard guarantee.
                        sr_reg        <= '0;
                    end else begin
                        frame_end_reg <= 1'b0;
                        tail_cnt_reg  <= tail_cnt_reg + 1'b1;
                    end
                end
            end else begin
                enc_valid_reg   <= 1'b0;
                frame_start_reg <= 1'b0;
                frame_end_reg   <= 1'b0;
            end
        end
    end

    assign enc_o         = enc_reg;
    assign enc_valid_o   = enc_valid_reg;
    assign frame_start_o = frame_start_reg;
    assign frame_end_o   = frame_end_reg;
    assign frame_ct_o    = frame_ct_reg;

endmodule

// File: doc/conv_frame_encoder.md
Name: conv_frame_encoder

Overview:
- Rate-1/2 convolutional encoder on the transmit side of the Viterbi link. Its output feeds the channel/error-injection stage, and the Viterbi decoder sits downstream.
- Accepts a serial info-bit stream with a valid/ready handshake.
- Groups the stream into fixed-length frames and appends K-1 zero tail bits per frame, so the decoder traceback always ends in state 0.
- Emits one 2-bit code symbol per accepted bit, with downstream backpressure and per-frame markers.

Parameters:
- K, 3, constraint length; the shift register holds K-1 past bits.
- G0, 3'b111, generator polynomial for enc_o[1]. MSB taps the current bit.
- G1, 3'b101, generator polynomial for enc_o[0]. MSB taps the current bit.
- FRAME_LEN, 256, number of info bits per frame; must be at least 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- data_i  input  1  info bit.
- data_valid_i  input  1  data_i is valid this cycle.
- data_ready_o  output  1  encoder accepts data_i this cycle.
- enc_o  output  2  code symbol {g0 bit, g1 bit}.
- enc_mask_o  output  2  per-bit symbol validity; 2'b11 unless punctured.
- enc_valid_o  output  1  enc_o is valid.
- enc_ready_i  input  1  downstream accepts enc_o.
- frame_start_o  output  1  qualifies the symbol of info bit 0 of a frame.
- frame_end_o  output  1  qualifies the last tail symbol of a frame.
- frame_ct_o  output  16  completed-frame counter; wraps at 65535 to 0.

Behaviour:
- Reset state: state=DATA, bit_cnt=0, tail_cnt=0, sr=0, enc_o=0, enc_mask_o=2'b11, enc_valid_o=0, frame_start_o=0, frame_end_o=0, frame_ct_o=0.
- Reset applies mid-frame: the partial frame is discarded and the next accepted bit is bit 0 of a new frame.
- adv = ~enc_valid_o | enc_ready_i.
  - enc_* and frame_* outputs are held stable while enc_valid_o=1 and enc_ready_i=0.
- Encode function: u = {b, sr[0], sr[1]}, where sr[0] is the most recent past bit.
  - enc bit1 = ^(u & G0); enc bit0 = ^(u & G1).
  - On each emitted symbol: sr <= {sr[K-3:0], b}.
- State DATA:
  - data_ready_o = adv.
  - On data_valid_i & adv: encode data_i, then enc_valid_o<=1.
  - frame_start_o <= (bit_cnt==0).
  - bit_cnt++. When bit_cnt==FRAME_LEN-1: bit_cnt<=0 and go to TAIL.
  - On adv without data_valid_i: enc_valid_o<=0 (bubble).
- State TAIL:
  - data_ready_o=0, combinationally, in every TAIL cycle.
  - On adv: encode b=0, enc_valid_o<=1, tail_cnt++.
  - On tail_cnt==K-2:
    - frame_end_o<=1 and frame_ct_o++.
    - tail_cnt<=0 and go to DATA.
    - sr is zero by construction; it is also force-cleared here.
  - frame_start_o<=0 throughout TAIL.
- Latency: one cycle from an accepted bit to its symbol on enc_o.
- Throughput: with enc_ready_i held at 1, one symbol per cycle.
  - Input stalls exactly K-1 cycles per frame.
  - Each frame emits FRAME_LEN+K-1 symbols.
- Simultaneous events:
  - rst has priority over everything.
  - enc_ready_i and a new input in the same cycle give back-to-back symbols with no bubble.
- Flag rules:
  - frame_start_o and frame_end_o are never 1 on the same symbol, because FRAME_LEN is at least 2.
  - frame_end_o is followed by frame_start_o on the next accepted bit.

Optional Feature:
- Macro: PUNCTURE_EN.
- Defined:
  - Rate-2/3 puncturing with pattern [11;10].
  - A symbol index counter is reset at frame_start.
  - Even-index symbols: enc_mask_o=2'b11.
  - Odd-index symbols: enc_mask_o=2'b10 and enc_o[0] forced to 0.
  - Tail symbols continue the index count.
- Not defined:
  - enc_mask_o is tied to 2'b11.
  - No index counter is built.
  - Encoder output is unmodified.

Test Plan:
- FRAME_LEN=8, enc_ready_i=1, input 1,0,0,0,0,0,0,0 →
  - symbols 11,10,11,00,00,00,00,00 followed by tail 00,00;
  - frame_start_o on symbol 0, frame_end_o on symbol 9;
  - frame_ct_o=1;
  - data_ready_o low for exactly 2 cycles.
- FRAME_LEN=8, input 0×7 then 1 →
  - symbol 7=11, tail symbols 10,11 (trellis flushed to state 0);
  - sr=0 after frame_end_o.
- Mid-frame backpressure: enc_ready_i=0 for 3 cycles after symbol 3 →
  - enc_o/enc_valid_o held for 3 cycles;
  - data_ready_o=0 during the stall;
  - no bit lost or duplicated; the full 10-symbol sequence matches the golden model.
- Reset mid-frame: rst for 1 cycle after 4 accepted bits →
  - all outputs return to reset values;
  - the next bit carries frame_start_o;
  - frame_ct_o unchanged at 0.
- Continuous valid for 3 frames plus random enc_ready_i, FRAME_LEN=256 →
  - 774 symbols;
  - frame_ct_o=3;
  - decoding by the Viterbi decoder reproduces all 768 info bits with zero errors.
- PUNCTURE_EN defined, FRAME_LEN=8, input 1,0,0,... →
  - enc_mask_o alternates 11,10 starting at frame_start;
  - odd symbols have enc_o[0]=0, e.g. symbol 1 = 10.
